// File: rtl/cellrv32_package.sv
// Shared address map and CTRL bit positions for the SPI host, also mirrored
// in the software headers.
package cellrv32_package;

   localparam logic [31:0] spi_base_c      = 32'hFFFF_FFA8;
   localparam int          spi_size_c      = 8;
   localparam logic [31:0] spi_ctrl_addr_c = spi_base_c;
   localparam logic [31:0] spi_rtx_addr_c  = spi_base_c + 32'd4;

   localparam int spi_ctrl_en_c      = 0;
   localparam int spi_ctrl_cpha_c    = 1;
   localparam int spi_ctrl_cpol_c    = 2;
   localparam int spi_ctrl_cs_sel0_c = 3;
   localparam int spi_ctrl_cs_sel2_c = 5;
   localparam int spi_ctrl_cs_en_c   = 6;
   localparam int spi_ctrl_cdiv0_c   = 8;
   localparam int spi_ctrl_cdiv7_c   = 15;
   localparam int spi_ctrl_irq_en_c  = 16;
   localparam int spi_ctrl_done_c    = 30;
   localparam int spi_ctrl_busy_c    = 31;

   // Number of address bits covered by a power-of-two sized window.
   function automatic int index_size_f(input int size);
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) >= size) return i;
      end
      return 32;
   endfunction

endpackage

// File: rtl/cellrv32_spi_host.sv
// Byte-wide SPI host: bus-mapped CTRL/DATA registers, clock prescaler and a
// two-phase-per-bit shift FSM supporting all four SPI modes.
module cellrv32_spi_host
   import cellrv32_package::*;
#(
   parameter int NUM_CS = 8
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [31:0]       addr_i,
   input  logic              rden_i,
   input  logic              wren_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic              ack_o,
   output logic              spi_clk_o,
   output logic              spi_dat_o,
   input  logic              spi_dat_i,
   output logic [NUM_CS-1:0] spi_csn_o,
   output logic              irq_o
);

   typedef enum logic [1:0] {S_IDLE, S_PH_A, S_PH_B, S_DONE} state_t;

   localparam int lo_c = index_size_f(spi_size_c);

   logic       acc, wr_ctrl, wr_data, rd_data, rd_ctrl;
   logic       en, cpha, cpol, cs_en, irq_en;
   logic [2:0] cs_sel;
   logic [7:0] cdiv;
   logic       done_flag, busy, sdi_ff, clk_next;
   logic [7:0] sreg, rx, tick;
   logic [2:0] cnt;
   state_t     state, state_next;
   logic       unused_bits;

   assign acc     = (addr_i[31:lo_c] == spi_base_c[31:lo_c]);
   assign wr_ctrl = acc & wren_i & ~addr_i[2];
   assign wr_data = acc & wren_i &  addr_i[2];
   assign rd_ctrl = acc & rden_i & ~addr_i[2];
   assign rd_data = acc & rden_i &  addr_i[2];
   assign busy    = (state != S_IDLE);
   assign unused_bits = ^{addr_i[1:0], data_i[31:17]};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= S_IDLE;
      else         state <= state_next;
   end

   // Clearing EN overrides every transition so an abort takes one cycle.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (wr_data) state_next = S_PH_A;
         S_PH_A: if (tick == cdiv) state_next = S_PH_B;
         S_PH_B: if (tick == cdiv) state_next = (cnt == 3'd7) ? S_DONE : S_PH_A;
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (!en) state_next = S_IDLE;
   end

   // Serial clock follows the phase being entered so it stays registered
   // yet aligned with the state register.
   always_comb begin
      clk_next = cpol;
      case (state_next)
         S_PH_A:  clk_next = cpol ^ cpha;
         S_PH_B:  clk_next = ~(cpol ^ cpha);
         default: clk_next = cpol;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sreg      <= '0;
         rx        <= '0;
         tick      <= '0;
         cnt       <= '0;
         sdi_ff    <= 1'b0;
         spi_clk_o <= 1'b0;
      end else begin
         spi_clk_o <= clk_next;
         if (en) begin
            case (state)
               S_IDLE: if (wr_data) begin
                  sreg <= data_i[7:0];
                  cnt  <= '0;
                  tick <= '0;
               end
               S_PH_A: if (tick == cdiv) begin
                  sdi_ff <= spi_dat_i;
                  tick   <= '0;
               end else begin
                  tick <= tick + 8'd1;
               end
               S_PH_B: if (tick == cdiv) begin
                  sreg <= {sreg[6:0], sdi_ff};
                  cnt  <= cnt + 3'd1;
                  tick <= '0;
               end else begin
                  tick <= tick + 8'd1;
               end
               S_DONE: rx <= sreg;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         en <= 1'b0; cpha <= 1'b0; cpol <= 1'b0; cs_en <= 1'b0; irq_en <= 1'b0;
         cs_sel    <= '0;
         cdiv      <= '0;
         done_flag <= 1'b0;
         ack_o     <= 1'b0;
         data_o    <= '0;
         irq_o     <= 1'b0;
         spi_csn_o <= '1;
      end else begin
         if (wr_ctrl) begin
            en     <= data_i[spi_ctrl_en_c];
            cpha   <= data_i[spi_ctrl_cpha_c];
            cpol   <= data_i[spi_ctrl_cpol_c];
            cs_sel <= data_i[spi_ctrl_cs_sel2_c:spi_ctrl_cs_sel0_c];
            cs_en  <= data_i[spi_ctrl_cs_en_c];
            cdiv   <= data_i[spi_ctrl_cdiv7_c:spi_ctrl_cdiv0_c];
            irq_en <= data_i[spi_ctrl_irq_en_c];
         end
         // A completing transfer beats a concurrent DATA read.
         if ((state == S_DONE) && en) done_flag <= 1'b1;
         else if (rd_data)            done_flag <= 1'b0;
         ack_o  <= acc & (rden_i | wren_i);
         data_o <= '0;
         if (rd_ctrl)
            data_o <= {busy, done_flag, 13'b0, irq_en, cdiv, 1'b0, cs_en, cs_sel, cpol, cpha, en};
         else if (rd_data)
            data_o <= {24'b0, rx};
         irq_o <= en & irq_en & done_flag;
         for (int i = 0; i < NUM_CS; i++)
            spi_csn_o[i] <= ~(en & cs_en & (32'(cs_sel) == i));
      end
   end

   assign spi_dat_o = sreg[7];

endmodule

// File: tb/tb_cellrv32_spi_host.sv
// Self-checking bench for cellrv32_spi_host: table of single-byte transfers in
// all SPI modes plus hand-written chip-select, busy-write, abort, irq and reset cases.
module tb_cellrv32_spi_host;
   import cellrv32_package::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] addr = '0;
   logic        rden = 1'b0;
   logic        wren = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ack, spi_clk, spi_mosi, spi_miso, irq;
   logic [7:0]  csn;
   logic        use_model = 1'b0;
   logic        model_bit = 1'b0;
   logic [31:0] rd;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  sb_q[$];

   always #5 clk = ~clk;
   assign spi_miso = use_model ? model_bit : spi_mosi;

   cellrv32_spi_host #(.NUM_CS(8)) dut (
      .clk_i(clk), .rstn_i(rstn), .addr_i(addr), .rden_i(rden), .wren_i(wren),
      .data_i(wdata), .data_o(rdata), .ack_o(ack), .spi_clk_o(spi_clk),
      .spi_dat_o(spi_mosi), .spi_dat_i(spi_miso), .spi_csn_o(csn), .irq_o(irq)
   );

   typedef struct {
      logic [31:0] ctrl;
      logic        model;
      logic [7:0]  mbyte;
      logic [7:0]  tx;
      logic [7:0]  exp_rx;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Bus tasks are entered and left on a falling clock edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; wren = 1'b1;
      @(negedge clk);
      wren = 1'b0;
      check("write_ack", {31'b0, ack}, 32'd1);
      $display("write addr=%h data=%h", a, d);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr = a; rden = 1'b1;
      @(negedge clk);
      rden = 1'b0;
      check("read_ack", {31'b0, ack}, 32'd1);
      d = rdata;
      $display("read  addr=%h data=%h", a, d);
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         bus_read(spi_ctrl_addr_c, rd);
         if (rd[spi_ctrl_done_c]) begin
            ok = 1;
            break;
         end
      end
      check("done_poll", {31'b0, ok}, 32'd1);
   endtask

   task automatic pop_rx(input string name);
      logic [7:0] exp;
      bus_read(spi_rtx_addr_c, rd);
      if (sb_q.size() == 0) begin
         check("sb_underflow", 32'd0, 32'd1);
      end else begin
         exp = sb_q.pop_front();
         check(name, rd, {24'b0, exp});
      end
   endtask

   // One table transfer; the slave model shifts on the leading edge for
   // CPHA=1 and on the trailing edge (bit 7 preloaded) for CPHA=0.
   task automatic run_vec(input vec_t v);
      logic       cpol, cpha, prev;
      int         cdiv, mi, leads, w;
      cpol = v.ctrl[2]; cpha = v.ctrl[1]; cdiv = int'(v.ctrl[15:8]);
      bus_write(spi_ctrl_addr_c, v.ctrl);
      bus_read(spi_ctrl_addr_c, rd);
      check("ctrl_readback", rd, v.ctrl & 32'h0001_FF7F);
      check("clk_idle_pre", {31'b0, spi_clk}, {31'b0, cpol});
      use_model = v.model;
      mi = 0; leads = 0; prev = spi_clk;
      model_bit = cpha ? 1'b0 : v.mbyte[7];
      bus_write(spi_rtx_addr_c, {24'b0, v.tx});
      sb_q.push_back(v.exp_rx);
      w = 16 * (cdiv + 1);
      for (int i = 0; i < w; i++) begin
         if (spi_clk !== prev) begin
            prev = spi_clk;
            if (spi_clk != cpol) begin
               leads++;
               if (cpha && mi < 8) begin
                  model_bit = v.mbyte[7-mi];
                  mi++;
               end
            end else if (!cpha && mi < 7) begin
               mi++;
               model_bit = v.mbyte[7-mi];
            end
         end
         @(negedge clk);
      end
      bus_read(spi_ctrl_addr_c, rd);
      check("busy_last_cycle", {30'b0, rd[31:30]}, 32'd2);
      bus_read(spi_ctrl_addr_c, rd);
      check("done_set", {30'b0, rd[31:30]}, 32'd1);
      check("leading_edges", leads, 32'd8);
      check("clk_idle_post", {31'b0, spi_clk}, {31'b0, cpol});
      pop_rx("rx_byte");
      check("mosi_held", {31'b0, spi_mosi}, {31'b0, v.exp_rx[7]});
      bus_read(spi_ctrl_addr_c, rd);
      check("done_cleared", {31'b0, rd[30]}, 32'd0);
      use_model = 1'b0;
   endtask

   initial begin
      vecs[0] = '{32'h0000_0001, 1'b0, 8'h00, 8'h3C, 8'h3C};
      vecs[1] = '{32'h0000_0101, 1'b0, 8'h00, 8'hA5, 8'hA5};
      vecs[2] = '{32'h0000_0203, 1'b1, 8'h96, 8'h00, 8'h96};
      vecs[3] = '{32'h0000_0307, 1'b1, 8'h3C, 8'hF0, 8'h3C};
      vecs[4] = '{32'h0000_0005, 1'b1, 8'hC3, 8'h5A, 8'hC3};
      vecs[5] = '{32'h0000_0701, 1'b1, 8'h5A, 8'hFF, 8'h5A};

      repeat (3) @(negedge clk);
      check("rst_clk", {31'b0, spi_clk}, 32'd0);
      check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
      check("rst_csn", {24'b0, csn}, 32'hFF);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_ack", {31'b0, ack}, 32'd0);
      check("rst_data", rdata, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      bus_read(spi_ctrl_addr_c, rd);
      check("rst_ctrl", rd, 32'd0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Chip-select decode
      bus_write(spi_ctrl_addr_c, 32'h69); @(negedge clk);
      check("cs5", {24'b0, csn}, 32'hDF);
      bus_write(spi_ctrl_addr_c, 32'h29); @(negedge clk);
      check("cs_en0", {24'b0, csn}, 32'hFF);
      bus_write(spi_ctrl_addr_c, 32'h68); @(negedge clk);
      check("cs_off", {24'b0, csn}, 32'hFF);
      bus_write(spi_ctrl_addr_c, 32'h79); @(negedge clk);
      check("cs7", {24'b0, csn}, 32'h7F);

      // A DATA write while busy must not disturb the running byte.
      bus_write(spi_ctrl_addr_c, 32'h101);
      bus_write(spi_rtx_addr_c, 32'hA5);
      sb_q.push_back(8'hA5);
      repeat (3) @(negedge clk);
      bus_write(spi_rtx_addr_c, 32'h11);
      wait_done();
      pop_rx("rx_busy_write");
      check("mosi_busy_write", {31'b0, spi_mosi}, 32'd1);

      // Abort by clearing EN mid-transfer.
      bus_write(spi_ctrl_addr_c, 32'h1_0141);
      bus_write(spi_rtx_addr_c, 32'h5A);
      repeat (8) @(negedge clk);
      check("abort_cs_active", {24'b0, csn}, 32'hFE);
      bus_write(spi_ctrl_addr_c, 32'h1_0140);
      @(negedge clk);
      bus_read(spi_ctrl_addr_c, rd);
      check("abort_ctrl", rd, 32'h0001_0140);
      check("abort_clk", {31'b0, spi_clk}, 32'd0);
      check("abort_csn", {24'b0, csn}, 32'hFF);
      sb_q.push_back(8'hA5);
      pop_rx("abort_rx_kept");
      repeat (40) @(negedge clk);
      check("abort_no_irq", {31'b0, irq}, 32'd0);
      bus_read(spi_ctrl_addr_c, rd);
      check("abort_no_done", {31'b0, rd[30]}, 32'd0);

      // Done interrupt and its clearing by a DATA read.
      bus_write(spi_ctrl_addr_c, 32'h1_0001);
      bus_write(spi_rtx_addr_c, 32'h69);
      sb_q.push_back(8'h69);
      wait_done();
      check("irq_set", {31'b0, irq}, 32'd1);
      pop_rx("irq_rx");
      check("irq_hold", {31'b0, irq}, 32'd1);
      @(negedge clk);
      check("irq_clear", {31'b0, irq}, 32'd0);

      // Asynchronous reset in the middle of a transfer.
      bus_write(spi_ctrl_addr_c, 32'h345);
      bus_write(spi_rtx_addr_c, 32'h80);
      repeat (6) @(negedge clk);
      check("pre_rst_mosi", {31'b0, spi_mosi}, 32'd1);
      check("pre_rst_csn", {24'b0, csn}, 32'hFE);
      #2 rstn = 1'b0;
      #1;
      check("arst_clk", {31'b0, spi_clk}, 32'd0);
      check("arst_mosi", {31'b0, spi_mosi}, 32'd0);
      check("arst_csn", {24'b0, csn}, 32'hFF);
      check("arst_irq", {31'b0, irq}, 32'd0);
      check("arst_ack", {31'b0, ack}, 32'd0);
      check("arst_data", rdata, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      bus_read(spi_ctrl_addr_c, rd);
      check("arst_ctrl_idle", rd, 32'd0);
      bus_read(spi_rtx_addr_c, rd);
      check("arst_rx", rd, 32'd0);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cellrv32_spi_host.md
# cellrv32_spi_host

Byte-oriented SPI host controller on the CPU IO bus, the upstream counterpart of the SDI device. It generates the serial clock, chip-selects and MOSI data that clock an SDI (or any external SPI device), and captures MISO into a readable RX register. Single-byte transfers, software-managed chip-select, programmable clock divider, all four SPI modes, done interrupt.

## Interface
Parameters:
- NUM_CS, 8, number of chip-select lines (1..8).

Ports:
- clk_i  in  1  global clock, rising edge
- rstn_i  in  1  global reset, asynchronous, active-low
- addr_i  in  32  bus address
- rden_i  in  1  read enable
- wren_i  in  1  write enable
- data_i  in  32  write data
- data_o  out  32  read data (zero when not reading)
- ack_o  out  1  access acknowledge
- spi_clk_o  out  1  serial clock
- spi_dat_o  out  1  MOSI
- spi_dat_i  in  1  MISO
- spi_csn_o  out  NUM_CS  chip-selects, low-active
- irq_o  out  1  transfer-done interrupt

## Operation
- Decode: access when addr_i[hi:lo] equals spi_base_c. Word offset 0 is CTRL and offset 4 is DATA.
- CTRL, r/w: bit0 EN; bit1 CPHA; bit2 CPOL; bits5:3 CS_SEL; bit6 CS_EN; bits15:8 CDIV; bit16 IRQ_EN.
- CTRL read-only bits: bit30 DONE (sticky); bit31 BUSY.
- DATA write: if EN=1 and BUSY=0, load sreg with data_i[7:0] and start a transfer. Otherwise the write is ignored but still acked.
- DATA read: returns the RX byte in bits 7:0 and clears DONE.
- Chip-select: spi_csn_o[CS_SEL] is 0 when EN&CS_EN; all other lines are 1. CS_SEL≥NUM_CS drives all lines to 1. Chip-select is independent of the FSM, so software frames multi-byte packets.
- FSM states: IDLE, PH_A, PH_B, DONE. BUSY = (state≠IDLE).
  - IDLE → PH_A on an accepted DATA write; cnt=0, tick=0.
  - PH_A (sample phase): when tick==CDIV, sample spi_dat_i into sdi_ff, go to PH_B, tick=0.
  - PH_B (shift phase): when tick==CDIV, sreg={sreg[6:0],sdi_ff} and cnt++. Go to DONE if cnt==7 before the increment, else to PH_A.
  - DONE: rx byte = sreg, set DONE, go to IDLE (one cycle).
- Phase timing: tick increments every clk in PH_A/PH_B. Each phase lasts CDIV+1 cycles.
- spi_dat_o = sreg[7] at all times (sreg is held after the transfer).
- spi_clk_o is registered:
  - Idle value is CPOL.
  - CPHA=0: CPOL in PH_A, ~CPOL in PH_B.
  - CPHA=1: ~CPOL in PH_A, CPOL in PH_B.
- EN cleared mid-transfer: next cycle the FSM returns to IDLE and spi_clk_o=CPOL. RX and DONE are unchanged, and all chip-selects go high.
- irq_o registered: EN & IRQ_EN & DONE.

## Timing
- Reset values: spi_clk_o=0, spi_dat_o=0, spi_csn_o=all 1, data_o=0, ack_o=0, irq_o=0. CTRL=0, sreg=0, rx=0, state IDLE.
- ack_o follows one cycle after any decoded rden/wren. data_o is valid in the same cycle as ack_o.
- DATA write seen at edge N: PH_A starts at N+1; BUSY reads 1 from N+1.
- Transfer length: 16·(CDIV+1) cycles of PH_A/PH_B, then 1 DONE cycle.
  - RX byte and DONE are visible at N+16·(CDIV+1)+2.
  - irq_o rises one cycle after DONE is set.
- CDIV=0 gives a serial clock of clk/2, the maximum rate.
- Simultaneous DATA read and DONE set: the set wins; DONE remains 1.
- CTRL write during a transfer takes effect immediately (mode and CDIV changes are software error, not guarded). EN=0 aborts the transfer as above.

## Structure
- Package cellrv32_package:
  - spi_base_c, spi_size_c, spi_ctrl_addr_c, spi_rtx_addr_c.
  - CTRL bit-index localparams, if shared with software headers; otherwise module-local.
- State enum typedef is module-local.
- No sub-module. Prescaler, FSM and bus interface live in one module (≈200 RTL lines).

## Test plan
- Reset: assert rstn_i mid-transfer → all outputs reach reset values asynchronously; BUSY=0 after release.
- Mode 0 loopback: CTRL EN=1, CDIV=1, write DATA 0xA5 with spi_dat_i=spi_dat_o → BUSY for 32 cycles; RX=0xA5, DONE=1; exactly 8 rising spi_clk_o edges.
- Mode 3: CPOL=1, CPHA=1, CDIV=3, external model drives 0x3C MSB-first on falling edges → RX=0x3C; spi_clk_o idles high before and after.
- Chip-select: CS_SEL=5, CS_EN=1 → spi_csn_o=8'b1101_1111. CS_EN=0 or EN=0 → 8'hFF.
- Write while busy / abort: second DATA write 0x11 during a transfer is ignored and the sreg stream is unchanged. Clearing EN at cycle 10 → IDLE next cycle, RX keeps its old value, no irq.
- Integration with cellrv32_sdi: host CDIV=7, mode 0; SDI TX FIFO holds 0xC3; host sends 0x5A → host RX=0xC3, SDI RX FIFO=0x5A. With IRQ_EN=1, irq_o asserts; it drops after the DATA read.
